nios2_oci_trace_monitor: RTL and testbench

NIOS2_OCI_TRACE_MONITOR -- requirements
Module: nios2_oci_trace_monitor

---
 rtl/nios2_oci_mon_pkg.sv | 17 +
 rtl/nios2_oci_mon_fifo.sv | 65 ++++++
 rtl/nios2_oci_trace_monitor.sv | 111 +++++++++++
 tb/tb_nios2_oci_trace_monitor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_mon_pkg.sv
// Shared FSM state type and default sizing for the OCI trace monitor.
// Optional build macro used by the monitor: OCI_MON_PARITY_EN.
package nios2_oci_mon_pkg;

    localparam int DCT_WIDTH_DEF  = 30;
    localparam int CNT_WIDTH_DEF  = 4;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int OVF_WIDTH      = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_ENDED
    } mon_state_e;

endpackage

// File: rtl/nios2_oci_mon_fifo.sv
// Capture FIFO for the trace monitor: storage, wrapping pointers, level.
// A push while full is only taken when a pop frees a slot in the same cycle.
module nios2_oci_mon_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (level_q != '0);
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            if (do_push && !do_pop) level_d = level_q + 1'b1;
            if (do_pop && !do_push) level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage is deliberately not reset; the level gates what is visible.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/nios2_oci_trace_monitor.sv
// OCI trace monitor: captures qualified DCT words, drains them, then ends.
// Build macro OCI_MON_PARITY_EN adds a stored parity bit on rd_parity.
module nios2_oci_trace_monitor
    import nios2_oci_mon_pkg::*;
#(
    parameter int DCT_WIDTH  = DCT_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DCT_WIDTH-1:0]          dct_buffer,
    input  logic [CNT_WIDTH-1:0]          dct_count,
    input  logic                          dct_valid,
    input  logic                          test_ending,
    input  logic                          test_has_ended,
    input  logic                          rd_ready,
    output logic                          rd_valid,
    output logic [DCT_WIDTH-1:0]          rd_data,
    output logic [CNT_WIDTH-1:0]          rd_count,
`ifdef OCI_MON_PARITY_EN
    output logic                          rd_parity,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [OVF_WIDTH-1:0]          overflow_cnt,
    output logic                          done
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
`ifdef OCI_MON_PARITY_EN
    localparam int FW = DCT_WIDTH + CNT_WIDTH + 1;
`else
    localparam int FW = DCT_WIDTH + CNT_WIDTH;
`endif

    mon_state_e           state_q;
    logic                 done_q;
    logic [OVF_WIDTH-1:0] ovf_q;
    logic [FW-1:0]        wdata, rdata;
    logic [LW-1:0]        level;
    logic                 full, active, push_req, pop, ovf_inc;

    assign active   = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
    assign push_req = ((state_q == ST_IDLE) || (state_q == ST_CAPTURE))
                      && dct_valid && (dct_count != '0) && !test_has_ended;
    assign rd_valid = active && (level != '0);
    assign pop      = rd_valid && rd_ready && !test_has_ended;
    assign ovf_inc  = push_req && full && !pop;

`ifdef OCI_MON_PARITY_EN
    assign wdata     = {^{dct_buffer, dct_count}, dct_count, dct_buffer};
    assign rd_parity = rd_valid ? rdata[FW-1] : 1'b0;
`else
    assign wdata     = {dct_count, dct_buffer};
`endif

    assign rd_data      = rd_valid ? rdata[DCT_WIDTH-1:0] : '0;
    assign rd_count     = rd_valid ? rdata[DCT_WIDTH +: CNT_WIDTH] : '0;
    assign fifo_level   = level;
    assign overflow_cnt = ovf_q;
    assign done         = done_q;

    nios2_oci_mon_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_req),
        .pop_i   (pop),
        .flush_i (test_has_ended),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .level_o (level),
        .full_o  (full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            ovf_q   <= '0;
        end else begin
            if (ovf_inc && (ovf_q != '1)) ovf_q <= ovf_q + 1'b1;
            if (test_has_ended) begin
                state_q <= ST_ENDED;
                done_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (test_ending)   state_q <= ST_DRAIN;
                        else if (push_req) state_q <= ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        if (test_ending) state_q <= ST_DRAIN;
                    end
                    // Exit only once the last word has been observed popped.
                    ST_DRAIN: begin
                        if (level == '0) begin
                            state_q <= ST_ENDED;
                            done_q  <= 1'b1;
                        end
                    end
                    ST_ENDED: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nios2_oci_trace_monitor.sv
// Directed testbench for nios2_oci_trace_monitor (default parameters).
// Parity checks are compiled in when OCI_MON_PARITY_EN is defined.
module tb_nios2_oci_trace_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        test_ending;
    logic        test_has_ended;
    logic        rd_ready;
    logic        rd_valid;
    logic [29:0] rd_data;
    logic [3:0]  rd_count;
    logic [3:0]  fifo_level;
    logic [15:0] overflow_cnt;
    logic        done;
`ifdef OCI_MON_PARITY_EN
    logic        rd_parity;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nios2_oci_trace_monitor dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_count       (rd_count),
`ifdef OCI_MON_PARITY_EN
        .rd_parity      (rd_parity),
`endif
        .fifo_level     (fifo_level),
        .overflow_cnt   (overflow_cnt),
        .done           (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [29:0] b,
                         input logic [3:0] c);
        dct_valid  = v;
        dct_buffer = b;
        dct_count  = c;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        drive(1'b0, '0, '0);
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        rd_ready       = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", rd_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_count", rd_count, 0);

        // Three words streamed with rd_ready high
        rd_ready = 1'b1;
        drive(1'b1, 30'h100, 4'd1);
        tick();
        chk("a_valid1", rd_valid, 1);
        chk("a_data1", rd_data, 30'h100);
        chk("a_cnt1", rd_count, 1);
        drive(1'b1, 30'h200, 4'd2);
        tick();
        chk("a_data2", rd_data, 30'h200);
        chk("a_cnt2", rd_count, 2);
        drive(1'b1, 30'h300, 4'd3);
        tick();
        chk("a_data3", rd_data, 30'h300);
        chk("a_cnt3", rd_count, 3);
        drive(1'b0, '0, '0);
        tick();
        chk("a_level0", fifo_level, 0);
        chk("a_valid0", rd_valid, 0);

        // Ten pushes into depth 8 with no reads
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 30'h10 + 30'(i), 4'(i + 1));
            tick();
        end
        drive(1'b0, '0, '0);
        chk("b_level8", fifo_level, 8);
        chk("b_ovf2", overflow_cnt, 2);
        chk("b_head", rd_data, 30'h10);
        chk("b_headcnt", rd_count, 1);
        tick();
        chk("b_hold", rd_data, 30'h10);
        chk("b_ovf_hold", overflow_cnt, 2);

        // Full with simultaneous push and pop
        drive(1'b1, 30'hAA, 4'd5);
        rd_ready = 1'b1;
        tick();
        drive(1'b0, '0, '0);
        chk("c_level8", fifo_level, 8);
        chk("c_ovf2", overflow_cnt, 2);
        for (int j = 1; j < 8; j++) begin
            chk($sformatf("c_data%0d", j), rd_data, 30'h10 + 30'(j));
            tick();
        end
        chk("c_last", rd_data, 30'hAA);
        chk("c_lastcnt", rd_count, 5);
        tick();
        chk("c_empty", fifo_level, 0);

        // Four stored, test_ending with a fifth push, then drain
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 30'h40 + 30'(i), 4'd1);
            tick();
        end
        drive(1'b1, 30'h44, 4'd2);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        drive(1'b1, 30'h99, 4'd1);
        chk("d_level5", fifo_level, 5);
        chk("d_done0", done, 0);
        rd_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("d_data%0d", j), rd_data, 30'h40 + 30'(j));
            tick();
        end
        chk("d_level0", fifo_level, 0);
        chk("d_done_early", done, 0);
        tick();
        chk("d_done1", done, 1);
        chk("d_valid0", rd_valid, 0);
        chk("d_ovf0", overflow_cnt, 0);

        // Six stored, abort together with test_ending
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 30'h60 + 30'(i), 4'd1);
            tick();
        end
        chk("e_level6", fifo_level, 6);
        test_has_ended = 1'b1;
        test_ending    = 1'b1;
        rd_ready       = 1'b1;
        tick();
        test_has_ended = 1'b0;
        test_ending    = 1'b0;
        chk("e_done", done, 1);
        chk("e_level0", fifo_level, 0);
        chk("e_valid0", rd_valid, 0);
        tick();
        tick();
        chk("e_terminal", done, 1);
        chk("e_nopush", fifo_level, 0);

        // Reset in the middle of a drain
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 30'h70 + 30'(i), 4'd1);
            tick();
        end
        drive(1'b0, '0, '0);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        chk("f_draining", fifo_level, 3);
        do_reset();
        chk("f_level0", fifo_level, 0);
        chk("f_valid0", rd_valid, 0);
        chk("f_done0", done, 0);

        // Zero-count words are discarded, then empty IDLE drains to ENDED
        drive(1'b1, 30'h55, 4'd0);
        tick();
        tick();
        chk("g_level0", fifo_level, 0);
        chk("g_ovf0", overflow_cnt, 0);
        chk("g_valid0", rd_valid, 0);
        drive(1'b0, '0, '0);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        chk("g_drain", done, 0);
        tick();
        chk("g_ended", done, 1);

`ifdef OCI_MON_PARITY_EN
        do_reset();
        chk("p_rst", rd_parity, 0);
        drive(1'b1, 30'h1, 4'd1);
        tick();
        chk("p_even", rd_parity, 0);
        drive(1'b1, 30'h1, 4'd3);
        rd_ready = 1'b1;
        tick();
        drive(1'b0, '0, '0);
        chk("p_odd", rd_parity, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
